// File: rtl/adder_core.sv
// Registered modulo-2^WIDTH adder.
// 4-bit carry-lookahead groups, group carries ripple.
module adder_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_sum;
  logic [NG-1:0]    w_gc;
  logic [WIDTH-1:0] r_res;

  assign w_g     = a & b;
  assign w_p     = a ^ b;
  assign w_gc[0] = 1'b0;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    logic [3:0] w_gg;
    logic [3:0] w_pp;
    logic       w_ci;

    assign w_gg = w_g[4*gi +: 4];
    assign w_pp = w_p[4*gi +: 4];
    assign w_ci = w_gc[gi];

    assign w_c[4*gi] = w_ci;
    assign w_c[4*gi+1] = w_gg[0]
                       | (w_pp[0] & w_ci);
    assign w_c[4*gi+2] = w_gg[1]
                       | (w_pp[1] & w_gg[0])
                       | (w_pp[1] & w_pp[0] & w_ci);
    assign w_c[4*gi+3] = w_gg[2]
                       | (w_pp[2] & w_gg[1])
                       | (w_pp[2] & w_pp[1] & w_gg[0])
                       | (w_pp[2] & w_pp[1] & w_pp[0]
                          & w_ci);

    // Top group's carry-out is the discarded wrap carry.
    if (gi < NG - 1) begin : g_co
      assign w_gc[gi+1] = w_gg[3]
                        | (w_pp[3] & w_gg[2])
                        | (w_pp[3] & w_pp[2] & w_gg[1])
                        | (w_pp[3] & w_pp[2] & w_pp[1]
                           & w_gg[0])
                        | (w_pp[3] & w_pp[2] & w_pp[1]
                           & w_pp[0] & w_ci);
    end
  end

  assign w_sum = w_p ^ w_c;

  always_ff @(posedge clk_i) begin
    if (!reset_i) r_res <= '0;
    else          r_res <= w_sum;
  end

  assign res = r_res;

endmodule

// File: tb/tb_adder_core.sv
// Scoreboard bench for adder_core: driver queues
// expected sums, monitor checks after each edge.
module tb_adder_core;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] res;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_exp[$];
  string      q_nam[$];
  bit         done = 1'b0;

  adder_core #(.WIDTH(8)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .a       (a),
    .b       (b),
    .res     (res)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(
    input string      nm,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Drive on negedge; DUT captures on next posedge.
  task automatic step(
    input string      nm,
    input logic       rst_n,
    input logic [7:0] va,
    input logic [7:0] vb,
    input logic [7:0] exp
  );
    @(negedge clk_i);
    reset_i = rst_n;
    a       = va;
    b       = vb;
    q_exp.push_back(exp);
    q_nam.push_back(nm);
  endtask

  // Monitor: compare after each edge, then confirm the
  // value holds while inputs change at the negedge.
  initial begin : monitor
    logic [7:0] last;
    string      lnm;
    bit         have;
    have = 1'b0;
    last = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (q_exp.size() > 0) begin
        last = q_exp.pop_front();
        lnm  = q_nam.pop_front();
        check(lnm, res, last);
        have = 1'b1;
      end
      @(negedge clk_i);
      #1;
      if (have)
        check({lnm, "_hold"}, res, last);
    end
  end

  initial begin : driver
    logic [7:0] ra;
    logic [7:0] rb;
    reset_i = 1'b0;
    a       = 8'd17;
    b       = 8'd25;

    step("rst0", 1'b0, 8'd17, 8'd25, 8'd0);
    step("rst1", 1'b0, 8'd17, 8'd25, 8'd0);
    step("rel",  1'b1, 8'd17, 8'd25, 8'd42);

    step("lat0", 1'b1, 8'd3,  8'd4,  8'd7);
    step("lat1", 1'b1, 8'd10, 8'd20, 8'd30);

    step("wrap0", 1'b1, 8'd255, 8'd1,   8'd0);
    step("wrap1", 1'b1, 8'd200, 8'd100, 8'd44);
    step("wrap2", 1'b1, 8'd255, 8'd255, 8'd254);

    step("grp0", 1'b1, 8'h0F, 8'h01, 8'h10);
    step("grp1", 1'b1, 8'hFF, 8'h00, 8'hFF);
    step("grp2", 1'b1, 8'h7F, 8'h01, 8'h80);
    step("grp3", 1'b1, 8'hF0, 8'h10, 8'h00);
    step("grp4", 1'b1, 8'h55, 8'hAA, 8'hFF);
    step("grp5", 1'b1, 8'h56, 8'hAA, 8'h00);

    step("mid0", 1'b1, 8'd1, 8'd2, 8'd3);
    step("mid1", 1'b1, 8'd5, 8'd6, 8'd11);
    step("mid2", 1'b0, 8'd9, 8'd9, 8'd0);
    step("mid3", 1'b1, 8'd9, 8'd9, 8'd18);

    for (int i = 0; i < 2000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      step("soak", 1'b1, ra, rb,
           8'((int'(ra) + int'(rb)) % 256));
    end

    for (int i = 0; i < 20; i++) begin
      if (q_exp.size() == 0) break;
      @(posedge clk_i);
    end
    #3;
    if (q_exp.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain left %0d expected 0",
               q_exp.size());
    end
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    if (!done) begin
      $display("FAIL timeout reached expected finish");
      $fatal(1, "timeout");
    end
  end

endmodule
